bitty_fetch_unit: RTL and testbench

Instruction-issuing front end for the bitty core: holds a small program memory, presents one 16-bit instruction at a time on the core's `instruction` input and drives the core's `run`/`done` handshake from the initiator side. It sits between the program loader (testbench or host) and `bitty_core`, advancing a program counter after each completed instruction until a halt word, end of memory, or a handshake timeout.

---
 rtl/bitty_fetch_unit.sv | 140 ++++++++++++++
 tb/tb_bitty_fetch_unit.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bitty_fetch_unit.sv
// Fetch/issue front end for the bitty core: program memory, PC sequencing and
// the initiator side of the run/done handshake with a watchdog on each instruction.
module bitty_fetch_unit #(
  parameter int          DEPTH     = 256,
  parameter int          AW        = 8,
  parameter logic [15:0] HALT_WORD = 16'hFFFF,
  parameter int          TIMEOUT   = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [15:0]   prog_data,
  input  logic          done,
  output logic          run,
  output logic [15:0]   instruction,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          halted,
  output logic          err,
  output logic [15:0]   instr_count
);

  localparam int            WW        = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] WDOG_LAST = WW'(TIMEOUT - 1);
  localparam logic [AW-1:0] PC_LAST   = AW'(DEPTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_HALTED,
    ST_ERROR
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [15:0]   instr_q, instr_d;
  logic [15:0]   instrCount_q, instrCount_d;
  logic [WW-1:0] wdog_q, wdog_d;

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] pcNext;
  logic [15:0]   memNext;
  logic          memWritable;

  assign pcNext      = pc_q + AW'(1);
  assign memNext     = mem[pcNext];
  assign memWritable = (state_q == ST_IDLE) || (state_q == ST_HALTED) || (state_q == ST_ERROR);

  // Program memory is deliberately not reset; writes are locked out while a program runs.
  always_ff @(posedge clk) begin
    if (prog_we && memWritable) begin
      mem[prog_addr] <= prog_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      pc_q         <= '0;
      instr_q      <= '0;
      instrCount_q <= '0;
      wdog_q       <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      instrCount_q <= instrCount_d;
      wdog_q       <= wdog_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    instrCount_d = instrCount_q;
    wdog_d       = wdog_q;
    case (state_q)
      ST_IDLE, ST_HALTED: begin
        if (start) begin
          pc_d         = '0;
          instrCount_d = '0;
          wdog_d       = '0;
          if (mem[0] == HALT_WORD) begin
            state_d = ST_HALTED;
          end else begin
            instr_d = mem[0];
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        wdog_d  = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (done) begin
          if (instrCount_q != 16'hFFFF) begin
            instrCount_d = instrCount_q + 16'd1;
          end
          // The last address halts in place rather than wrapping to 0.
          if (pc_q == PC_LAST) begin
            state_d = ST_HALTED;
          end else if (memNext == HALT_WORD) begin
            pc_d    = pcNext;
            state_d = ST_HALTED;
          end else begin
            pc_d    = pcNext;
            instr_d = memNext;
            state_d = ST_ISSUE;
          end
        end else begin
          wdog_d = wdog_q + WW'(1);
          if (wdog_q == WDOG_LAST) begin
            state_d = ST_ERROR;
          end
        end
      end
      ST_ERROR: begin
        state_d = ST_ERROR;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // run must fall in the very cycle done rises so the core never re-captures.
  assign run         = (state_q == ST_ISSUE) || ((state_q == ST_WAIT) && !done);
  assign instruction = instr_q;
  assign pc          = pc_q;
  assign busy        = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
  assign halted      = (state_q == ST_HALTED);
  assign err         = (state_q == ST_ERROR);
  assign instr_count = instrCount_q;

endmodule

// File: tb/tb_bitty_fetch_unit.sv
// Self-checking bench for bitty_fetch_unit: directed handshake/timeout/reset steps
// plus randomized programs checked against a walk-the-memory reference model.
module tb_bitty_fetch_unit;

  localparam logic [15:0] HALT = 16'hFFFF;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, progWe, done;
  logic [7:0]  progAddr;
  logic [15:0] progData;
  logic        run, busy, halted, err;
  logic [15:0] instruction, instrCount;
  logic [7:0]  pc;

  logic        sStart, sProgWe, sDone;
  logic [1:0]  sProgAddr;
  logic [15:0] sProgData;
  logic        sRun, sBusy, sHalted, sErr;
  logic [15:0] sInstruction, sInstrCount;
  logic [1:0]  sPc;

  int total = 0;
  int bad   = 0;

  logic [15:0] refMem [256];
  logic [15:0] expSeq [$];
  int          expPc;

  int          coreLat;
  int          coreCnt;
  logic [15:0] issued [$];
  int          sCoreCnt;
  logic [15:0] sIssued [$];

  always #5 clk = ~clk;

  bitty_fetch_unit #(.DEPTH(256), .AW(8), .HALT_WORD(16'hFFFF), .TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .start(start), .prog_we(progWe), .prog_addr(progAddr),
    .prog_data(progData), .done(done), .run(run), .instruction(instruction), .pc(pc),
    .busy(busy), .halted(halted), .err(err), .instr_count(instrCount)
  );

  bitty_fetch_unit #(.DEPTH(4), .AW(2), .HALT_WORD(16'hFFFF), .TIMEOUT(15)) dutSmall (
    .clk(clk), .reset(reset), .start(sStart), .prog_we(sProgWe), .prog_addr(sProgAddr),
    .prog_data(sProgData), .done(sDone), .run(sRun), .instruction(sInstruction), .pc(sPc),
    .busy(sBusy), .halted(sHalted), .err(sErr), .instr_count(sInstrCount)
  );

  // Core model: captures on the first run cycle of an instruction, raises done
  // coreLat cycles after that capture (coreLat==0 means it never finishes).
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      done    <= 1'b0;
      coreCnt <= 0;
    end else if (run) begin
      if (coreCnt == 0) issued.push_back(instruction);
      if (coreLat != 0 && coreCnt + 1 == coreLat) begin
        done    <= 1'b1;
        coreCnt <= 0;
      end else begin
        done    <= 1'b0;
        coreCnt <= coreCnt + 1;
      end
    end
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      sDone    <= 1'b0;
      sCoreCnt <= 0;
    end else if (sRun) begin
      if (sCoreCnt == 0) sIssued.push_back(sInstruction);
      if (sCoreCnt == 2) begin
        sDone    <= 1'b1;
        sCoreCnt <= 0;
      end else begin
        sDone    <= 1'b0;
        sCoreCnt <= sCoreCnt + 1;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic we, input logic [7:0] addr, input logic [15:0] data,
                               input logic st);
    progWe   = we;
    progAddr = addr;
    progData = data;
    start    = st;
    tick();
    progWe = 1'b0;
    start  = 1'b0;
  endtask

  task automatic writeWord(input logic [7:0] addr, input logic [15:0] data);
    applyStimulus(1'b1, addr, data, 1'b0);
    refMem[addr] = data;
  endtask

  // Reference: walk memory from 0, issuing until a halt word or the last address.
  task automatic computeExpected();
    int a;
    expSeq.delete();
    a = 0;
    forever begin
      if (refMem[a] == HALT) break;
      expSeq.push_back(refMem[a]);
      if (a == 255) break;
      a++;
    end
    expPc = a;
  endtask

  task automatic runProgram(input int lat, input logic we0, input logic [15:0] d0,
                            input logic wWait);
    int cycles;
    int n;
    coreLat = lat;
    issued.delete();
    computeExpected();
    applyStimulus(we0, 8'd0, d0, 1'b1);
    if (we0) refMem[0] = d0;
    cycles = 1;
    checkOutput("startPc", 32'(pc), 32'd0);
    checkOutput("startCount", 32'(instrCount), 32'd0);
    if (expSeq.size() > 0) checkOutput("firstRun", 32'(run), 32'd1);
    while (!halted && !err && cycles < 4000) begin
      if (wWait && cycles == 2) applyStimulus(1'b1, 8'd1, ~refMem[1], 1'b0);
      else tick();
      cycles++;
    end
    n = expSeq.size();
    checkOutput("haltedFlag", 32'(halted), 32'd1);
    checkOutput("haltPc", 32'(pc), 32'(expPc));
    checkOutput("haltCount", 32'(instrCount), 32'(n));
    checkOutput("haltCycle", 32'(cycles), 32'(n * (lat + 1) + 1));
    checkOutput("issuedCount", 32'(issued.size()), 32'(n));
    for (int i = 0; i < n && i < issued.size(); i++) begin
      checkOutput("issuedWord", 32'(issued[i]), 32'(expSeq[i]));
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL globalTimeout observed=running expected=finished");
    $fatal(1, "[TB] simulation time limit");
  end

  initial begin
    int c;
    logic expRun;
    logic [15:0] w;
    reset = 1'b0; start = 1'b0; progWe = 1'b0; progAddr = '0; progData = '0;
    sStart = 1'b0; sProgWe = 1'b0; sProgAddr = '0; sProgData = '0;
    coreLat = 3;
    for (int i = 0; i < 256; i++) refMem[i] = 16'h0000;

    $display("[TB] reset then idle");
    for (int i = 0; i < 3; i++) tick();
    checkOutput("rstRun", 32'(run), 32'd0);
    checkOutput("rstInstr", 32'(instruction), 32'd0);
    checkOutput("rstPc", 32'(pc), 32'd0);
    checkOutput("rstFlags", {29'd0, busy, halted, err}, 32'd0);
    checkOutput("rstCount", 32'(instrCount), 32'd0);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("idleRun", 32'(run), 32'd0);
      checkOutput("idleBusy", 32'(busy), 32'd0);
    end

    $display("[TB] two-instruction program with halt word");
    writeWord(8'd0, 16'h2048);
    writeWord(8'd1, 16'h4090);
    writeWord(8'd2, HALT);
    issued.delete();
    applyStimulus(1'b0, 8'd0, 16'd0, 1'b1);
    for (c = 1; c <= 9; c++) begin
      expRun = (c >= 1 && c <= 3) || (c >= 5 && c <= 7);
      checkOutput("dirRun", 32'(run), 32'(expRun));
      if (c >= 1 && c <= 4) checkOutput("dirInstrA", 32'(instruction), 32'h2048);
      if (c >= 5 && c <= 8) checkOutput("dirInstrB", 32'(instruction), 32'h4090);
      if (c == 8) checkOutput("dirNotHalted", 32'(halted), 32'd0);
      if (c < 9) tick();
    end
    checkOutput("dirHalted", 32'(halted), 32'd1);
    checkOutput("dirPc", 32'(pc), 32'd2);
    checkOutput("dirCount", 32'(instrCount), 32'd2);
    checkOutput("dirIssuedN", 32'(issued.size()), 32'd2);
    if (issued.size() == 2) begin
      checkOutput("dirIssued0", 32'(issued[0]), 32'h2048);
      checkOutput("dirIssued1", 32'(issued[1]), 32'h4090);
    end

    $display("[TB] watchdog timeout");
    writeWord(8'd0, 16'h1234);
    coreLat = 0;
    applyStimulus(1'b0, 8'd0, 16'd0, 1'b1);
    for (c = 1; c < 16; c++) tick();
    checkOutput("toBusy16", 32'(busy), 32'd1);
    checkOutput("toErr16", 32'(err), 32'd0);
    tick();
    checkOutput("toErr17", 32'(err), 32'd1);
    checkOutput("toRun17", 32'(run), 32'd0);
    checkOutput("toBusy17", 32'(busy), 32'd0);
    checkOutput("toInstr", 32'(instruction), 32'h1234);
    applyStimulus(1'b0, 8'd0, 16'd0, 1'b1);
    tick();
    checkOutput("toStartIgnored", {30'd0, err, busy}, 32'd2);
    writeWord(8'd0, 16'h5555);
    reset = 1'b0;
    #1;
    checkOutput("toRstErr", 32'(err), 32'd0);
    tick();
    reset = 1'b1;
    tick();
    coreLat = 3;

    $display("[TB] reset mid-WAIT, then write lockout during WAIT");
    writeWord(8'd1, 16'h1111);
    writeWord(8'd2, 16'h2222);
    writeWord(8'd3, HALT);
    applyStimulus(1'b0, 8'd0, 16'd0, 1'b1);
    tick();
    checkOutput("midRunBefore", 32'(run), 32'd1);
    reset = 1'b0;
    #1;
    checkOutput("midRunAsync", 32'(run), 32'd0);
    checkOutput("midBusyAsync", 32'(busy), 32'd0);
    tick();
    reset = 1'b1;
    tick();
    runProgram(3, 1'b0, 16'd0, 1'b1);
    runProgram(3, 1'b0, 16'd0, 1'b0);

    $display("[TB] randomized programs");
    for (int it = 0; it < 12; it++) begin
      int len;
      int lat;
      logic we0;
      len = $urandom_range(0, 10);
      lat = $urandom_range(1, 6);
      for (int a = 0; a < len; a++) writeWord(8'(a), 16'($urandom_range(0, 16'hFFFE)));
      writeWord(8'(len), HALT);
      we0 = ($urandom_range(0, 3) == 0);
      w = 16'($urandom_range(0, 16'hFFFE));
      runProgram(lat, we0, w, 1'b0);
    end

    $display("[TB] full memory without halt word");
    for (int a = 0; a < 256; a++) writeWord(8'(a), 16'($urandom_range(0, 16'hFFFE)));
    runProgram(2, 1'b0, 16'd0, 1'b0);

    $display("[TB] DEPTH=4 end of memory");
    for (int a = 0; a < 4; a++) begin
      sProgWe = 1'b1; sProgAddr = 2'(a); sProgData = 16'(16'h0A00 + a);
      tick();
    end
    sProgWe = 1'b0;
    sIssued.delete();
    sStart = 1'b1;
    tick();
    sStart = 1'b0;
    c = 1;
    while (!sHalted && c < 200) begin
      tick();
      c++;
    end
    checkOutput("smallHalted", 32'(sHalted), 32'd1);
    checkOutput("smallCycle", 32'(c), 32'd17);
    checkOutput("smallPc", 32'(sPc), 32'd3);
    checkOutput("smallCount", 32'(sInstrCount), 32'd4);
    checkOutput("smallIssuedN", 32'(sIssued.size()), 32'd4);
    for (int i = 0; i < 4 && i < sIssued.size(); i++) begin
      checkOutput("smallIssued", 32'(sIssued[i]), 32'(16'h0A00 + i));
    end
    tick();
    checkOutput("smallNoWrapPc", 32'(sPc), 32'd3);
    checkOutput("smallNoWrapRun", 32'(sRun), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
